// File: rtl/mb_fetch_param.sv
// Macroblock fetch unit: walks the Y (and optionally U/V) block of one macroblock in a
// word-addressed planar frame store and assembles the words into flat pixel buffers.
module mb_fetch_param #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int CHROMA_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [5:0]        mb_x_i,
   input  logic [5:0]        mb_y_i,
   input  logic [6:0]        frame_w_mb_i,
   input  logic [ADDR_W-1:0] y_base_i,
   input  logic [ADDR_W-1:0] u_base_i,
   input  logic [ADDR_W-1:0] v_base_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic              data_valid_i,
   output logic [2047:0]     luma_o,
   output logic [511:0]      cb_o,
   output logic [511:0]      cr_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int BPW   = DATA_W / 8;
   localparam int Y_WPR = 16 / BPW;
   localparam int C_WPR = 8 / BPW;

   localparam logic [1:0]        Y_LAST_COL = 2'(Y_WPR - 1);
   localparam logic [1:0]        C_LAST_COL = 2'(C_WPR - 1);
   localparam logic [ADDR_W-1:0] A_16       = ADDR_W'(16);
   localparam logic [ADDR_W-1:0] A_8        = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] A_YWPR     = ADDR_W'(Y_WPR);
   localparam logic [ADDR_W-1:0] A_CWPR     = ADDR_W'(C_WPR);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH_Y = 3'd1,
      S_FETCH_U = 3'd2,
      S_FETCH_V = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t            r_state;
   logic [3:0]        r_row;
   logic [1:0]        r_col;
   logic [5:0]        r_mb_x;
   logic [5:0]        r_mb_y;
   logic [6:0]        r_fw;
   logic [ADDR_W-1:0] r_y_base;
   logic [ADDR_W-1:0] r_u_base;
   logic [ADDR_W-1:0] r_v_base;
   logic              r_req;
   logic [ADDR_W-1:0] r_addr;
   logic              r_busy;
   logic              r_done;
   logic [2047:0]     r_luma;
   logic [511:0]      r_cb;
   logic [511:0]      r_cr;

   state_t            w_state_n;
   logic [3:0]        w_row_n;
   logic [1:0]        w_col_n;
   logic              w_last_col;
   logic              w_last_row;
   logic              w_load;
   logic [5:0]        w_mb_x;
   logic [5:0]        w_mb_y;
   logic [6:0]        w_fw;
   logic [ADDR_W-1:0] w_y_base;
   logic [ADDR_W-1:0] w_u_base;
   logic [ADDR_W-1:0] w_v_base;
   logic [ADDR_W-1:0] w_addr_n;

   function automatic state_t next_plane(input state_t cur);
      state_t nxt;
      case (cur)
         S_FETCH_Y: nxt = (CHROMA_EN != 0) ? S_FETCH_U : S_DONE;
         S_FETCH_U: nxt = S_FETCH_V;
         default:   nxt = S_DONE;
      endcase
      return nxt;
   endfunction

   function automatic logic [ADDR_W-1:0] plane_addr(
      input logic [ADDR_W-1:0] base,
      input logic [5:0]        mby,
      input logic [5:0]        mbx,
      input logic [6:0]        fw,
      input logic [3:0]        row,
      input logic [1:0]        col,
      input logic              is_luma
   );
      logic [ADDR_W-1:0] line;
      logic [ADDR_W-1:0] stride;
      logic [ADDR_W-1:0] xoff;
      if (is_luma) begin
         line   = ADDR_W'(mby) * A_16 + ADDR_W'(row);
         stride = ADDR_W'(fw) * A_YWPR;
         xoff   = ADDR_W'(mbx) * A_YWPR;
      end else begin
         line   = ADDR_W'(mby) * A_8 + ADDR_W'(row);
         stride = ADDR_W'(fw) * A_CWPR;
         xoff   = ADDR_W'(mbx) * A_CWPR;
      end
      return base + line * stride + xoff + ADDR_W'(col);
   endfunction

   // Sequencing: next state and row/col counters; a stall simply holds everything.
   always_comb begin
      w_state_n  = r_state;
      w_row_n    = r_row;
      w_col_n    = r_col;
      w_last_col = 1'b0;
      w_last_row = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_n = S_FETCH_Y;
               w_row_n   = 4'd0;
               w_col_n   = 2'd0;
            end else begin
               w_state_n = S_IDLE;
            end
         end
         S_FETCH_Y, S_FETCH_U, S_FETCH_V: begin
            if (r_state == S_FETCH_Y) begin
               w_last_col = (r_col == Y_LAST_COL);
               w_last_row = (r_row == 4'd15);
            end else begin
               w_last_col = (r_col == C_LAST_COL);
               w_last_row = (r_row == 4'd7);
            end
            if (!data_valid_i) begin
               w_state_n = r_state;
            end else if (!w_last_col) begin
               w_col_n = r_col + 2'd1;
            end else if (!w_last_row) begin
               w_col_n = 2'd0;
               w_row_n = r_row + 4'd1;
            end else begin
               w_col_n   = 2'd0;
               w_row_n   = 4'd0;
               w_state_n = next_plane(r_state);
            end
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   // Parameter view for the next cycle: fresh inputs on the accepting edge, latched copies otherwise.
   always_comb begin
      w_load   = (r_state == S_IDLE) && start_i;
      w_mb_x   = w_load ? mb_x_i       : r_mb_x;
      w_mb_y   = w_load ? mb_y_i       : r_mb_y;
      w_fw     = w_load ? frame_w_mb_i : r_fw;
      w_y_base = w_load ? y_base_i     : r_y_base;
      w_u_base = w_load ? u_base_i     : r_u_base;
      w_v_base = w_load ? v_base_i     : r_v_base;
   end

   // Address of the word that will be requested next cycle, so addr_o can be a flop.
   always_comb begin
      w_addr_n = {ADDR_W{1'b0}};
      case (w_state_n)
         S_FETCH_Y: w_addr_n = plane_addr(w_y_base, w_mb_y, w_mb_x, w_fw, w_row_n, w_col_n, 1'b1);
         S_FETCH_U: w_addr_n = plane_addr(w_u_base, w_mb_y, w_mb_x, w_fw, w_row_n, w_col_n, 1'b0);
         S_FETCH_V: w_addr_n = plane_addr(w_v_base, w_mb_y, w_mb_x, w_fw, w_row_n, w_col_n, 1'b0);
         default:   w_addr_n = {ADDR_W{1'b0}};
      endcase
   end

   // Control state, latched request parameters and registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_row    <= 4'd0;
         r_col    <= 2'd0;
         r_mb_x   <= 6'd0;
         r_mb_y   <= 6'd0;
         r_fw     <= 7'd0;
         r_y_base <= {ADDR_W{1'b0}};
         r_u_base <= {ADDR_W{1'b0}};
         r_v_base <= {ADDR_W{1'b0}};
         r_req    <= 1'b0;
         r_addr   <= {ADDR_W{1'b0}};
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_row    <= w_row_n;
         r_col    <= w_col_n;
         r_mb_x   <= w_mb_x;
         r_mb_y   <= w_mb_y;
         r_fw     <= w_fw;
         r_y_base <= w_y_base;
         r_u_base <= w_u_base;
         r_v_base <= w_v_base;
         r_req    <= (w_state_n == S_FETCH_Y) || (w_state_n == S_FETCH_U) ||
                     (w_state_n == S_FETCH_V);
         r_addr   <= w_addr_n;
         r_busy   <= (w_state_n != S_IDLE);
         r_done   <= (w_state_n == S_DONE);
      end
   end

   // Pixel capture: byte k of the word lands at column col*BPW+k of the active plane.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_luma <= {2048{1'b0}};
         r_cb   <= {512{1'b0}};
         r_cr   <= {512{1'b0}};
      end else if (data_valid_i) begin
         for (int k = 0; k < BPW; k++) begin
            case (r_state)
               S_FETCH_Y: r_luma[(int'(r_row) * 32'sd16 + int'(r_col) * BPW + k) * 8 +: 8] <= data_i[k * 8 +: 8];
               S_FETCH_U: r_cb[(int'(r_row) * 32'sd8 + int'(r_col) * BPW + k) * 8 +: 8]    <= data_i[k * 8 +: 8];
               S_FETCH_V: r_cr[(int'(r_row) * 32'sd8 + int'(r_col) * BPW + k) * 8 +: 8]    <= data_i[k * 8 +: 8];
               default: begin
                  r_luma <= r_luma;
               end
            endcase
         end
      end else begin
         r_luma <= r_luma;
      end
   end

   assign req_o  = r_req;
   assign addr_o = r_addr;
   assign busy_o = r_busy;
   assign done_o = r_done;
   assign luma_o = r_luma;
   assign cb_o   = r_cb;
   assign cr_o   = r_cr;

endmodule
